// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU sequencer: data and field
//               widths, the packed instruction layout, opcode encodings,
//               the controller state type and small opcode classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W  = 9;
  localparam int OPC_W   = 4;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = OPC_W + 2 * REG_AW + DATA_W;  // 19

  // Instruction word: [18:15] opcode, [14:12] rd, [11:9] rs, [8:0] imm9
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] imm;
  } instr_t;

  localparam logic [OPC_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SRL  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'b1001;
  localparam logic [OPC_W-1:0] OP_MOVI = 4'b1010;
  localparam logic [OPC_W-1:0] OP_NOP  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // 1100..1110 are unassigned encodings.
  function automatic logic op_is_illegal(input logic [OPC_W-1:0] op);
    return (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
  endfunction

  // Every real ALU operation (AND..MOVI) is encoded below NOP and writes rd.
  function automatic logic op_writes_reg(input logic [OPC_W-1:0] op);
    return (op <= OP_MOVI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NREGS x DATA_W register file. Two combinational read ports
//               for operand fetch, one combinational debug read port and one
//               synchronous write port. Synchronous active-low reset to 0.
// Ports       : clk, rst_n           - clock, sync active-low reset
//               rd_addr_a/rd_data_a  - operand read port A
//               rd_addr_b/rd_data_b  - operand read port B
//               dbg_raddr/dbg_rdata  - debug read port
//               wr_en/wr_addr/wr_data- write port
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign dbg_rdata = regs_q[dbg_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle fetch/decode/execute/writeback controller that
//               drives an external combinational 9-bit ALU from an 8x9
//               register file. HALT is handled locally and never reaches
//               the ALU; unassigned opcodes run as NOP and set a sticky err.
// Ports       : clk, rst_n          - clock, sync active-low reset
//               start               - begin at PC=0 (IDLE/HALTED only)
//               imem_req/imem_addr  - instruction fetch request / address
//               imem_valid/imem_data- fetch response
//               alu_a/alu_b/alu_op  - registered ALU operands and opcode
//               alu_out             - ALU combinational result
//               busy/halted/err     - status
//               retire              - pulse per completed instruction
//               dbg_raddr/dbg_rdata - debug register read
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int NREGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OPC_W-1:0]   alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic               retire,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  state_t            state_q,  state_d;
  logic [PC_W-1:0]   pc_q,     pc_d;
  instr_t            ir_q,     ir_d;
  logic [DATA_W-1:0] alu_a_q,  alu_a_d;
  logic [DATA_W-1:0] alu_b_q,  alu_b_d;
  logic [OPC_W-1:0]  alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q,    err_d;

  logic              rf_we;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [OPC_W-1:0]  dec_op;

  // Port A always reads R[rd], port B R[rs]; both are sampled in DECODE,
  // so rd==rs sees the old value long before WB writes the new one.
  alu_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (ir_q.rd),
    .rd_data_a (rd_val),
    .rd_addr_b (ir_q.rs),
    .rd_data_b (rs_val),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .wr_en     (rf_we),
    .wr_addr   (ir_q.rd),
    .wr_data   (result_q)
  );

  // Operand selection. NOP, HALT and unassigned opcodes fall to the
  // default: zero operands with NOP presented to the ALU.
  always_comb begin
    dec_a  = '0;
    dec_b  = '0;
    dec_op = OP_NOP;
    case (ir_q.opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin
        dec_a  = rd_val;
        dec_b  = rs_val;
        dec_op = ir_q.opcode;
      end
      OP_NOT, OP_MOV, OP_SLL, OP_SRL: begin
        dec_a  = rs_val;
        dec_op = ir_q.opcode;
      end
      OP_ADDI, OP_SUBI: begin
        dec_a  = rd_val;
        dec_b  = ir_q.imm;
        dec_op = ir_q.opcode;
      end
      OP_MOVI: begin
        dec_b  = ir_q.imm;
        dec_op = ir_q.opcode;
      end
      default: begin
        dec_op = OP_NOP;
      end
    endcase
  end

  // alu_op_d defaults to NOP so the registered opcode is only non-NOP for
  // the single EXEC cycle that follows DECODE.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = OP_NOP;
    result_d = result_q;
    err_d    = err_q;
    rf_we    = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q.opcode == OP_HALT) begin
          // PC left pointing at the HALT instruction.
          state_d = S_HALTED;
        end else begin
          alu_a_d  = dec_a;
          alu_b_d  = dec_b;
          alu_op_d = dec_op;
          if (op_is_illegal(ir_q.opcode)) begin
            err_d = 1'b1;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        state_d  = S_WB;
      end
      S_WB: begin
        rf_we   = op_writes_reg(ir_q.opcode);
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_NOP;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted    = (state_q == S_HALTED);
  assign err       = err_q;
  assign retire    = (state_q == S_WB);

endmodule
`default_nettype wire
